// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between instruction fetch (IF, read-only)
//   and load/store (LS). One transaction in flight at a time; the memory
//   request fields are registered at accept. A per-transaction timeout forces
//   an error completion if the memory does not respond.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   if_req_i / if_addr_i       IF read request and address
//   if_gnt_o                   IF request accepted (1-cycle pulse)
//   if_rvalid_o/rdata_o/err_o  IF response, data, timeout error
//   ls_req_i / ls_we_i / ls_addr_i / ls_wdata_i / ls_wsize_i   LS request
//   ls_gnt_o / ls_rvalid_o / ls_rdata_o / ls_err_o             LS handshake
//   mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_wsize_o  memory request
//   mem_gnt_i / mem_rvalid_i / mem_rdata_i                         memory handshake
//
// Build option
//   ARB_RR_EN  round-robin on simultaneous requests (default: LS over IF)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; accept the arbitration winner
// REQ    | mem_req_o high, waiting for mem_gnt_i
// RESP   | granted, waiting for mem_rvalid_i
module mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_err_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  input  logic [1:0]    ls_wsize_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ls_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [1:0]    mem_wsize_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  // Counter holds k-1 in the k-th cycle after accept, so the timeout
  // completion lands exactly TIMEOUT_CYCLES cycles after the grant.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          owner_ls_q, owner_ls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_wsize_q, mem_wsize_d;

  logic          pick_ls;
  logic          done;
  logic          done_err;
  logic          real_done;
  logic          timeout;
  logic [DW-1:0] resp_data;

`ifdef ARB_RR_EN
  logic last_ls_q, last_ls_d;
  // On contention the requester that was not served last wins.
  assign pick_ls = ls_req_i & (~if_req_i | ~last_ls_q);
`else
  assign pick_ls = ls_req_i;
`endif

  assign timeout   = (cnt_q == CNT_LAST);
  // Response in REQ only counts when the grant arrives in the same cycle.
  assign real_done = ((state_q == S_REQ) & mem_gnt_i & mem_rvalid_i) |
                     ((state_q == S_RESP) & mem_rvalid_i);

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wsize_d = mem_wsize_q;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
`ifdef ARB_RR_EN
    last_ls_d   = last_ls_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req_i | ls_req_i) begin
          owner_ls_d = pick_ls;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
`ifdef ARB_RR_EN
          last_ls_d  = pick_ls;
`endif
          if (pick_ls) begin
            ls_gnt_o    = 1'b1;
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
            mem_wsize_d = ls_wsize_i;
          end else begin
            if_gnt_o    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_wsize_d = 2'b10;
          end
        end
      end
      S_REQ, S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (real_done) begin
          done = 1'b1;
        end else if (timeout) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if ((state_q == S_REQ) && mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_ls_q  <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wsize_q <= 2'b00;
`ifdef ARB_RR_EN
      last_ls_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wsize_q <= mem_wsize_d;
`ifdef ARB_RR_EN
      last_ls_q   <= last_ls_d;
`endif
    end
  end

  // Timeout completions return zero data.
  assign resp_data   = (done & ~done_err) ? mem_rdata_i : '0;

  assign if_rvalid_o = done & ~owner_ls_q;
  assign if_err_o    = done_err & ~owner_ls_q;
  assign if_rdata_o  = owner_ls_q ? '0 : resp_data;
  assign ls_rvalid_o = done & owner_ls_q;
  assign ls_err_o    = done_err & owner_ls_q;
  assign ls_rdata_o  = owner_ls_q ? resp_data : '0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wsize_o = mem_wsize_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic [1:0]    ls_wsize_i;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [1:0]    mem_wsize_o;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wsize_i(ls_wsize_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wsize_o(mem_wsize_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        ls;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wsize;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_wsize;
  } vec_t;

  resp_t exp_q[$];
  resp_t mon_e;
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    resp_cyc = -1;
  int    acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard
  always @(negedge clk) begin
    if (if_rvalid_o === 1'b1 || ls_rvalid_o === 1'b1) begin
      checks++;
      resp_cyc = cyc;
      if (if_rvalid_o && ls_rvalid_o) begin
        errors++;
        $display("FAIL both_rvalid actual if=%0b ls=%0b required one", if_rvalid_o, ls_rvalid_o);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid actual if=%0b ls=%0b required none", if_rvalid_o, ls_rvalid_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (ls_rvalid_o !== mon_e.ls ||
            (mon_e.ls ? ls_rdata_o : if_rdata_o) !== mon_e.rdata ||
            (mon_e.ls ? ls_err_o : if_err_o) !== mon_e.err ||
            (mon_e.ls ? if_rdata_o : ls_rdata_o) !== 32'h0 ||
            (mon_e.ls ? if_err_o : ls_err_o) !== 1'b0) begin
          errors++;
          $display("FAIL response actual ls=%0b if_rd=%h ls_rd=%h if_err=%0b ls_err=%0b required ls=%0b rd=%h err=%0b",
                   ls_rvalid_o, if_rdata_o, ls_rdata_o, if_err_o, ls_err_o,
                   mon_e.ls, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v);
    resp_t e;
    if_req_i   = !v.ls;
    ls_req_i   = v.ls;
    if_addr_i  = v.ls ? 32'hDEAD0000 : v.addr;
    ls_we_i    = v.we;
    ls_addr_i  = v.addr;
    ls_wdata_i = v.wdata;
    ls_wsize_i = v.wsize;
    @(negedge clk);
    chk("gnt", {if_gnt_o, ls_gnt_o}, v.ls ? 2'b01 : 2'b10);
    e.ls = v.ls; e.rdata = v.rdata; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    chk("mem_fields", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wsize_o},
        {1'b1, v.exp_we, v.addr, v.exp_wdata, v.exp_wsize});
    repeat (v.gnt_dly) begin
      @(posedge clk); #1;
      chk("mem_req_hold", mem_req_o, 1'b1);
    end
    mem_gnt_i    = 1'b1;
    mem_rdata_i  = v.rdata;
    mem_rvalid_i = (v.rv_dly == 0);
    @(posedge clk); #1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (v.rv_dly > 0) begin
      chk("mem_req_drop", mem_req_o, 1'b0);
      repeat (v.rv_dly - 1) begin
        @(posedge clk); #1;
      end
      mem_rvalid_i = 1'b1;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
    end
    chk("resp_seen", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_ls;
    logic [31:0] d;
    resp_t       e;

    //            ls    we    addr          wdata         wsize  g  r  rdata         exp_we exp_wdata     exp_wsize
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 2'b00, 0, 2, 32'hDEAD_BEEF, 1'b0, 32'h0,         2'b10};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 2'b01, 0, 1, 32'h0,         1'b1, 32'h1234_5678, 2'b01};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h1111_1111, 2'b10, 2, 1, 32'hCAFE_F00D, 1'b0, 32'h1111_1111, 2'b10};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         2'b01, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h0,         2'b10};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0203, 32'h0000_00FF, 2'b00, 1, 0, 32'h0,         1'b1, 32'h0000_00FF, 2'b00};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         2'b11, 0, 3, 32'h5555_AAAA, 1'b0, 32'h0,         2'b11};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0800, 32'hFFFF_0000, 2'b00, 3, 4, 32'h1357_9BDF, 1'b0, 32'h0,         2'b10};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0900, 32'h0000_0077, 2'b10, 7, 0, 32'h2468_ACE0, 1'b1, 32'h0000_0077, 2'b10};

    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0;
    ls_req_i = 0; ls_we_i = 0; ls_addr_i = '0; ls_wdata_i = '0; ls_wsize_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs",
        {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wsize_o, if_gnt_o, ls_gnt_o,
         if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o, if_rdata_o, ls_rdata_o}, '0);

    // Both requesters held high for four back-to-back transactions
    if_addr_i = 32'h1000; ls_addr_i = 32'h2000; ls_we_i = 0; ls_wsize_i = 2'b10; ls_wdata_i = '0;
    if_req_i = 1'b1; ls_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      exp_ls = (i % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      d = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("arb_gnt", {if_gnt_o, ls_gnt_o}, exp_ls ? 2'b01 : 2'b10);
      e.ls = exp_ls; e.rdata = d; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      chk("arb_addr", mem_addr_o, exp_ls ? 32'h2000 : 32'h1000);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = d;
      if (i == 3) begin
        if_req_i = 1'b0; ls_req_i = 1'b0;
      end
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end
    chk("arb_resp_seen", exp_q.size(), 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Memory never grants: forced error completion TO cycles after accept
    if_req_i = 1'b1; if_addr_i = 32'h40; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("to_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
    acc_cyc = cyc;
    e.ls = 1'b0; e.rdata = 32'h0; e.err = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    repeat (TO - 1) begin
      chk("to_req_hold", mem_req_o, 1'b1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("to_req_drop", mem_req_o, 1'b0);
    chk("to_resp_seen", exp_q.size(), 0);
    chk("to_latency", resp_cyc - acc_cyc, TO);
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("to_late_rvalid", {if_rvalid_o, ls_rvalid_o}, 2'b00);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;

    // Reset during RESP of an LS read drops the transaction
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h500; ls_wdata_i = 32'h99; ls_wsize_i = 2'b10;
    @(negedge clk);
    chk("rst_gnt", {if_gnt_o, ls_gnt_o}, 2'b01);
    @(posedge clk); #1;
    ls_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outputs",
        {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wsize_o, if_gnt_o, ls_gnt_o,
         if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o, if_rdata_o, ls_rdata_o}, '0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    chk("rst_no_rvalid", {ls_rvalid_o, ls_rdata_o}, '0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
